// File: rtl/module_arbitro_corrector_pkg.sv
// Shared types and constants for the Hamming(7,4) arbiter/corrector slice.
package pkg_hamming;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned HAM_W  = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Registered result presented to the consumer
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYN_W-1:0]  sindrome;
    logic              error;
    logic              src;
  } result_t;

  // Payload bits {i3,i2,i1,i0} of a word laid out as [i3,i2,i1,c2,i0,c1,c0]
  function automatic logic [DATA_W-1:0] payload(input logic [HAM_W-1:0] w);
    return {w[6], w[5], w[4], w[2]};
  endfunction

endpackage

// File: rtl/module_arbitro_corrector_if.sv
// Requester and consumer handshake bundle for module_arbitro_corrector.
interface module_arbitro_corrector_if #(
  parameter int unsigned CNT_W = 8
);
  import pkg_hamming::*;

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ*HAM_W-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [DATA_W-1:0]      out_data_o;
  logic [SYN_W-1:0]       out_sindrome_o;
  logic                   out_error_o;
  logic                   out_src_o;
  logic [CNT_W-1:0]       err_count_o;

  // Sources and consumer side
  modport master (
    output req_valid_i, req_data_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_data_o, out_sindrome_o,
           out_error_o, out_src_o, err_count_o
  );

  // Arbiter/corrector side
  modport slave (
    input  req_valid_i, req_data_i, out_ready_i,
    output req_ready_o, out_valid_o, out_data_o, out_sindrome_o,
           out_error_o, out_src_o, err_count_o
  );
endinterface

// File: rtl/module_arbitro_corrector_detector.sv
// Hamming(7,4) syndrome detector; syndrome value is the 1-based position of the bad bit.
module module_detector_error
  import pkg_hamming::*;
(
  input  logic [HAM_W-1:0] word,
  output logic [SYN_W-1:0] sindrome_c,
  output logic             error_c
);

  assign sindrome_c[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
  assign sindrome_c[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
  assign sindrome_c[2] = word[3] ^ word[4] ^ word[5] ^ word[6];
  assign error_c       = |sindrome_c;

endmodule

// File: rtl/module_arbitro_corrector.sv
// Two-requester round-robin front end sharing one Hamming(7,4) SEC detector.
module module_arbitro_corrector
  import pkg_hamming::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  module_arbitro_corrector_if.slave  bus
);

  state_t            state_q, state_d;
  logic              rr_q;        // requester favoured next when both are valid
  logic              grant_any;
  logic              grant_idx;
  logic [HAM_W-1:0]  word_sel;
  logic [HAM_W-1:0]  word_q;
  logic              src_q;
  logic [SYN_W-1:0]  syn;
  logic              syn_err;
  logic [HAM_W-1:0]  fix_mask;
  logic [HAM_W-1:0]  word_fix;
  result_t           res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ld_word;
  logic              ld_res;
  logic              cnt_inc;

  // Grant selection: alternate under contention, otherwise take the lone valid requester
  always_comb begin
    grant_any = |bus.req_valid_i;
    grant_idx = bus.req_valid_i[1];
    if (&bus.req_valid_i) begin
      grant_idx = rr_q;
    end
    word_sel = grant_idx ? bus.req_data_i[2*HAM_W-1:HAM_W] : bus.req_data_i[HAM_W-1:0];
  end

  assign bus.req_ready_o = (state_q == IDLE && grant_any) ? (N_REQ'(1) << grant_idx) : '0;

  module_detector_error u_detector (
    .word       (word_q),
    .sindrome_c (syn),
    .error_c    (syn_err)
  );

  // Single-bit correction: syndrome s flips word bit s-1
  always_comb begin
    fix_mask = '0;
    if (syn != '0) begin
      fix_mask = HAM_W'(1) << (syn - SYN_W'(1));
    end
    word_fix = word_q ^ fix_mask;
  end

  // Next state and datapath load enables
  always_comb begin
    state_d = state_q;
    ld_word = 1'b0;
    ld_res  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          ld_word = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        ld_res  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.out_ready_i) begin
          cnt_inc = res_q.error && (cnt_q != '1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Word capture, result register and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= 1'b0;
      word_q <= '0;
      src_q  <= 1'b0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (ld_word) begin
        word_q <= word_sel;
        src_q  <= grant_idx;
        rr_q   <= ~grant_idx;
      end
      if (ld_res) begin
        res_q.data     <= payload(word_fix);
        res_q.sindrome <= syn;
        res_q.error    <= syn_err;
        res_q.src      <= src_q;
      end
      if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid_o    = (state_q == SEND);
  assign bus.out_data_o     = res_q.data;
  assign bus.out_sindrome_o = res_q.sindrome;
  assign bus.out_error_o    = res_q.error;
  assign bus.out_src_o      = res_q.src;
  assign bus.err_count_o    = cnt_q;

endmodule
